register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//   MIPS general-purpose register file feeding the ALU's rs/rt operands: 32 x 32-bit registers,
//   two combinational read ports, one clocked write port. Sits between decode and the ALU;
//   write-back data (ALU result or memory load) returns on the write port. Register 0 reads zero.
// PARAMETERS
//   DATA_W   32            register width
//   ADDR_W   5             register index width (2**ADDR_W registers)
//   GP_INIT  32'h0000_1800 reset value of $gp (r28)
//   SP_INIT  32'h0000_3FFC reset value of $sp (r29)
// PORTS
//   clk         in   1       clock; all state updates on rising edge
//   reset       in   1       synchronous, active-high reset
//   read_reg1   in   ADDR_W  rs index
//   read_reg2   in   ADDR_W  rt index
//   write_reg   in   ADDR_W  destination index (rd or rt, chosen upstream)
//   write_data  in   DATA_W  write-back value
//   reg_write   in   1       write enable
//   read_data1  out  DATA_W  rs operand to ALU
//   read_data2  out  DATA_W  rt operand to ALU / store data
// BEHAVIOUR
//   - Single clock domain (clk); reset is synchronous and active-high. No asynchronous paths.
//   - Reset: on any rising edge with reset=1, all registers <= 0 except r28<=GP_INIT, r29<=SP_INIT.
//     Reset has priority over a simultaneous write; the write is dropped, including a mid-program write.
//   - While reset=1, read_data1 and read_data2 are forced to 0 combinationally.
//     After the first reset edge they follow storage (r28/r29 show init values).
//   - Write: on a rising edge with reset=0, reg_write=1 and write_reg!=0, regs[write_reg] <= write_data.
//     A write to r0 is silently discarded; r0 is never stored and always reads 0.
//   - Read: combinational, zero-latency. read_dataN = (read_regN==0) ? 0 : regs[read_regN].
//   - Same-cycle read/write of the same index: see CONFIGURATION. Both ports resolve independently;
//     read_reg1==read_reg2 returns identical data on both.
//   - No X propagation: storage is fully defined after the first reset edge. Before the first reset,
//     contents are unspecified.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined: write-first forwarding. If reg_write=1, reset=0, write_reg!=0 and
//     write_reg==read_regN, then read_dataN = write_data in the same cycle, before the edge.
//     Supports a pipelined datapath without a separate WB->ID forwarding path.
//   REGFILE_BYPASS_EN undefined: read-first. read_dataN shows the old contents until the edge,
//     then the new value. Single-cycle datapath default.
// STRUCTURE
//   Shared package mips_pkg:
//     - REG_ZERO=0, REG_GP=28, REG_SP=29
//     - DATA_W/ADDR_W defaults
//     - reg_idx_t (ADDR_W-bit) and word_t (DATA_W-bit) typedefs, shared with ALU and decoder
//   One sub-module: regfile_read_port. It holds the index decode, the r0 zero-force, the reset
//     force and the optional bypass mux, and is instantiated twice (rs, rt). Storage and the write
//     logic stay in register_file.
// TESTING
//   1 Reset: reset=1 for 1 edge, then read r0, r5, r28, r29 -> 0, 0, 32'h1800, 32'h3FFC;
//     outputs are 0 while reset=1.
//   2 Write/read: write r8=32'hDEAD_BEEF and r9=32'h0000_0001 on two edges; read_reg1=8, read_reg2=9
//     -> DEAD_BEEF, 1; both ports on 8 -> DEAD_BEEF on both.
//   3 r0 protection: reg_write=1, write_reg=0, write_data=32'hFFFF_FFFF; read r0 -> 0 before and after the edge.
//   4 Same-cycle hazard: r10=5; drive write r10=7 and read_reg1=10 in the same cycle. Before the edge
//     -> 7 with REGFILE_BYPASS_EN, 5 without; after the edge -> 7 in both builds.
//   5 Reset vs write: reset=1 and reg_write=1, write_reg=29, write_data=32'h1234 on the same edge
//     -> r29 reads 32'h3FFC after reset drops.
//   6 Sweep: write regs[i]=i*32'h0101_0101 for i=1..31, then read all through both ports
//     -> expected values; reg_write=0 cycles leave contents unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register indices, widths and word/index types
// used by the register file, ALU and decoder.
package mips_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = reg_idx_t'(0);
   localparam reg_idx_t REG_GP   = reg_idx_t'(28);
   localparam reg_idx_t REG_SP   = reg_idx_t'(29);

endpackage

// File: rtl/register_file_if.sv
// Register file access bundle: two read ports (rs/rt) and one write-back port.
// The master side belongs to decode/write-back, the slave side to the register file.
interface register_file_if;
   import mips_pkg::*;

   reg_idx_t read_reg1;
   reg_idx_t read_reg2;
   reg_idx_t write_reg;
   word_t    write_data;
   logic     reg_write;
   word_t    read_data1;
   word_t    read_data2;

   modport master (
      output read_reg1,
      output read_reg2,
      output write_reg,
      output write_data,
      output reg_write,
      input  read_data1,
      input  read_data2
   );

   modport slave (
      input  read_reg1,
      input  read_reg2,
      input  write_reg,
      input  write_data,
      input  reg_write,
      output read_data1,
      output read_data2
   );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port of the register file.
// Handles index decode, r0 reads-as-zero, the zero force while reset is held and,
// when REGFILE_BYPASS_EN is defined, write-first forwarding of the in-flight write.
module regfile_read_port
   import mips_pkg::*;
(
   input  logic     reset,
   input  reg_idx_t rd_idx,
   input  word_t    regs [1:NUM_REGS-1],
   output word_t    rd_data
`ifdef REGFILE_BYPASS_EN
   ,
   input  logic     wr_fire,
   input  reg_idx_t wr_idx,
   input  word_t    wr_data
`endif
);

   // Select the operand: zero for r0 or during reset, otherwise storage (or the pending write).
   always_comb begin
      rd_data = '0;
      if (!reset && (rd_idx != REG_ZERO)) begin
`ifdef REGFILE_BYPASS_EN
         if (wr_fire && (wr_idx == rd_idx))
            rd_data = wr_data;
         else
            rd_data = regs[rd_idx];
`else
         rd_data = regs[rd_idx];
`endif
      end
   end

endmodule

// File: rtl/register_file.sv
// MIPS general-purpose register file: 32 x 32-bit, two combinational read ports,
// one clocked write port. r0 is not stored and always reads zero.
// Widths come from mips_pkg (DATA_W, ADDR_W).
// Build option: define REGFILE_BYPASS_EN for write-first forwarding on the read
// ports; left undefined, reads return the old contents until the write edge.
module register_file
   import mips_pkg::*;
#(
   parameter word_t GP_INIT = 32'h0000_1800,
   parameter word_t SP_INIT = 32'h0000_3FFC
)(
   input  logic           clk,
   input  logic           reset,
   register_file_if.slave bus
);

   word_t regs [1:NUM_REGS-1];
   logic  wr_fire;

   // A write commits only outside reset and never to r0.
   assign wr_fire = bus.reg_write && !reset && (bus.write_reg != REG_ZERO);

   // Storage update: reset loads the init image and wins over any simultaneous write.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 1; i < NUM_REGS; i++)
            regs[i] <= '0;
         regs[REG_GP] <= GP_INIT;
         regs[REG_SP] <= SP_INIT;
      end else if (wr_fire) begin
         regs[bus.write_reg] <= bus.write_data;
      end
   end

   regfile_read_port u_port_rs (
      .reset   (reset),
      .rd_idx  (bus.read_reg1),
      .regs    (regs),
      .rd_data (bus.read_data1)
`ifdef REGFILE_BYPASS_EN
      ,
      .wr_fire (wr_fire),
      .wr_idx  (bus.write_reg),
      .wr_data (bus.write_data)
`endif
   );

   regfile_read_port u_port_rt (
      .reset   (reset),
      .rd_idx  (bus.read_reg2),
      .regs    (regs),
      .rd_data (bus.read_data2)
`ifdef REGFILE_BYPASS_EN
      ,
      .wr_fire (wr_fire),
      .wr_idx  (bus.write_reg),
      .wr_data (bus.write_data)
`endif
   );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: the stimulus process queues expected read data,
// a monitor process pops each entry and compares it against the live read ports.
module tb_register_file;
   import mips_pkg::*;

   typedef struct {
      string name;
      word_t exp1;
      word_t exp2;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   exp_t exp_q [$];

   register_file_if bus ();

   register_file dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks pending", exp_q.size());
      $fatal(1, "watchdog expired");
   end

   // Monitor: compare both read ports whenever an expectation is queued.
   initial begin
      exp_t e;
      forever begin
         wait (exp_q.size() > 0);
         e = exp_q.pop_front();
         checks++;
         if (bus.read_data1 !== e.exp1) begin
            errors++;
            $display("FAIL %s port1: got %h expected %h", e.name, bus.read_data1, e.exp1);
         end
         checks++;
         if (bus.read_data2 !== e.exp2) begin
            errors++;
            $display("FAIL %s port2: got %h expected %h", e.name, bus.read_data2, e.exp2);
         end
      end
   end

   task automatic expect_rd(input string name, input word_t e1, input word_t e2);
      exp_t e;
      e.name = name;
      e.exp1 = e1;
      e.exp2 = e2;
      exp_q.push_back(e);
      #1;
   endtask

   // Advance through one rising edge; inputs are then driven at the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_rd(input reg_idx_t a, input reg_idx_t b);
      bus.read_reg1 = a;
      bus.read_reg2 = b;
      #1;
   endtask

   task automatic set_wr(input logic en, input reg_idx_t idx, input word_t d);
      bus.reg_write  = en;
      bus.write_reg  = idx;
      bus.write_data = d;
   endtask

   initial begin
      word_t hazard_pre;
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      set_wr(1'b0, 5'd0, '0);
      set_rd(5'd28, 5'd29);

      // Reset: outputs forced to zero before and during reset.
      expect_rd("reset_pre_edge", 32'h0, 32'h0);
      tick();
      expect_rd("reset_held", 32'h0, 32'h0);
      reset = 1'b0;
      #1;
      expect_rd("reset_gp_sp", 32'h0000_1800, 32'h0000_3FFC);
      set_rd(5'd0, 5'd5);
      expect_rd("reset_r0_r5", 32'h0, 32'h0);

      // Write/read.
      set_wr(1'b1, 5'd8, 32'hDEAD_BEEF);
      tick();
      set_wr(1'b1, 5'd9, 32'h0000_0001);
      tick();
      set_wr(1'b0, 5'd0, '0);
      set_rd(5'd8, 5'd9);
      expect_rd("wr_r8_r9", 32'hDEAD_BEEF, 32'h0000_0001);
      set_rd(5'd8, 5'd8);
      expect_rd("same_index", 32'hDEAD_BEEF, 32'hDEAD_BEEF);

      // r0 protection.
      set_rd(5'd0, 5'd0);
      set_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
      #1;
      expect_rd("r0_pre_edge", 32'h0, 32'h0);
      tick();
      set_wr(1'b0, 5'd0, '0);
      #1;
      expect_rd("r0_post_edge", 32'h0, 32'h0);

      // Same-cycle read/write hazard.
      set_wr(1'b1, 5'd10, 32'd5);
      tick();
      set_wr(1'b1, 5'd10, 32'd7);
      set_rd(5'd10, 5'd10);
`ifdef REGFILE_BYPASS_EN
      hazard_pre = 32'd7;
`else
      hazard_pre = 32'd5;
`endif
      expect_rd("hazard_pre_edge", hazard_pre, hazard_pre);
      tick();
      set_wr(1'b0, 5'd0, '0);
      #1;
      expect_rd("hazard_post_edge", 32'd7, 32'd7);

      // Reset versus simultaneous write to r29.
      reset = 1'b1;
      set_wr(1'b1, 5'd29, 32'h0000_1234);
      set_rd(5'd29, 5'd8);
      expect_rd("reset_force_zero", 32'h0, 32'h0);
      tick();
      reset = 1'b0;
      set_wr(1'b0, 5'd0, '0);
      #1;
      expect_rd("reset_beats_write", 32'h0000_3FFC, 32'h0);

      // Sweep: fill r1..r31, then read back through both ports in opposite orders.
      for (int i = 1; i < NUM_REGS; i++) begin
         set_wr(1'b1, reg_idx_t'(i), word_t'(i) * 32'h0101_0101);
         tick();
      end
      set_wr(1'b0, 5'd0, '0);
      for (int i = 1; i < NUM_REGS; i++) begin
         set_rd(reg_idx_t'(i), reg_idx_t'(NUM_REGS - i));
         expect_rd("sweep", word_t'(i) * 32'h0101_0101, word_t'(NUM_REGS - i) * 32'h0101_0101);
      end

      // Disabled write cycles must not disturb contents.
      set_wr(1'b0, 5'd5, 32'hCAFE_F00D);
      tick();
      tick();
      tick();
      set_rd(5'd5, 5'd31);
      expect_rd("idle_no_write", 32'h0505_0505, 32'h1F1F_1F1F);
      set_rd(5'd0, 5'd28);
      expect_rd("sweep_r0_r28", 32'h0, 32'h1C1C_1C1C);

      while (exp_q.size() > 0) #1;
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
